uart_echo_master: RTL and testbench

Wishbone initiator that sits on the other end of the user-area UART CSR slave at 0x3000_00xx and drives it with no CPU involvement. It polls the UART status register, pulls received bytes out of the RX data register into a small internal FIFO, and writes them back to the TX data register whenever the transmitter is idle. Use it as a hardware loopback/echo engine for bring-up and as a bus-level exerciser of the UART slave.

---
 rtl/uart_echo_master.sv | 261 ++++++++++++++++++++++++++
 tb/tb_uart_echo_master.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_echo_master.sv
// Wishbone initiator that drives the user-area UART CSR block as a hardware
// echo engine: polls status, drains RX bytes into a small FIFO, and writes
// them back to TX whenever the transmitter reports idle.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// IDLE     | parked, no bus activity; leaves when enable is high
// GAP      | idle spacing between status polls
// RD_STAT  | bus read of the status register in flight
// DECIDE   | one cycle: pick RX read, TX write, or go back to GAP
// RD_RX    | bus read of the RX data register in flight
// WR_TX    | bus write of the FIFO head to the TX data register
module uart_echo_master #(
    parameter logic [31:0] BASE_ADR     = 32'h3000_0000,
    parameter logic [7:0]  RX_OFS       = 8'h00,
    parameter logic [7:0]  TX_OFS       = 8'h04,
    parameter logic [7:0]  STAT_OFS     = 8'h08,
    parameter int          RX_VALID_BIT = 0,
    parameter int          TX_BUSY_BIT  = 4,
    parameter int          FIFO_DEPTH   = 4,
    parameter int          POLL_GAP     = 16,
    parameter int          TIMEOUT      = 255
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          enable,
    output logic                          wbm_cyc_o,
    output logic                          wbm_stb_o,
    output logic                          wbm_we_o,
    output logic [3:0]                    wbm_sel_o,
    output logic [31:0]                   wbm_adr_o,
    output logic [31:0]                   wbm_dat_o,
    input  logic                          wbm_ack_i,
    input  logic [31:0]                   wbm_dat_i,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic [15:0]                   echo_count,
    output logic                          bus_err
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = AW + 1;
    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
    // GAP always lasts at least one cycle; POLL_GAP>0 gives exactly POLL_GAP idle cycles.
    localparam int GAP_LOAD = (POLL_GAP > 0) ? POLL_GAP - 1 : 0;
    localparam int GW = (GAP_LOAD > 1) ? $clog2(GAP_LOAD + 1) : 1;

    localparam logic [31:0] STAT_ADR = BASE_ADR + {24'h0, STAT_OFS};
    localparam logic [31:0] RX_ADR   = BASE_ADR + {24'h0, RX_OFS};
    localparam logic [31:0] TX_ADR   = BASE_ADR + {24'h0, TX_OFS};

    typedef enum logic [2:0] {
        S_IDLE,
        S_GAP,
        S_RD_STAT,
        S_DECIDE,
        S_RD_RX,
        S_WR_TX
    } state_t;

    state_t          state_q;
    state_t          state_d;
    logic [GW-1:0]   gap_cnt;
    logic [TW-1:0]   to_cnt;
    logic [LW-1:0]   wr_ptr;
    logic [LW-1:0]   rd_ptr;
    logic [7:0]      mem [FIFO_DEPTH];
    logic            rx_valid_q;
    logic            tx_busy_q;

    logic            start_stat;
    logic            start_rx;
    logic            start_tx;
    logic            push;
    logic            pop;
    logic            bus_end;
    logic            bus_abort;
    logic            ack_ok;
    logic            to_hit;
    logic            fifo_full;
    logic            fifo_empty;
    logic            unused_dat;

    // Only the status bits and the RX byte are meaningful in read data.
    assign unused_dat = ^wbm_dat_i;

    assign ack_ok     = wbm_cyc_o & wbm_ack_i;
    assign to_hit     = wbm_cyc_o & ~wbm_ack_i & (to_cnt == TW'(TIMEOUT));
    assign fifo_empty = (wr_ptr == rd_ptr);
    assign fifo_full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic plus one-cycle strobes that launch/finish bus cycles.
    always_comb begin
        state_d    = state_q;
        start_stat = 1'b0;
        start_rx   = 1'b0;
        start_tx   = 1'b0;
        push       = 1'b0;
        pop        = 1'b0;
        bus_end    = 1'b0;
        bus_abort  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (enable) begin
                    state_d    = S_RD_STAT;
                    start_stat = 1'b1;
                end
            end
            S_GAP: begin
                if (gap_cnt == '0) begin
                    if (enable) begin
                        state_d    = S_RD_STAT;
                        start_stat = 1'b1;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            S_RD_STAT: begin
                if (ack_ok) begin
                    bus_end = 1'b1;
                    state_d = enable ? S_DECIDE : S_IDLE;
                end else if (to_hit) begin
                    bus_abort = 1'b1;
                    state_d   = enable ? S_GAP : S_IDLE;
                end
            end
            S_DECIDE: begin
                if (!enable) begin
                    state_d = S_IDLE;
                end else if (rx_valid_q && !fifo_full) begin
                    state_d  = S_RD_RX;
                    start_rx = 1'b1;
                end else if (!fifo_empty && !tx_busy_q) begin
                    state_d  = S_WR_TX;
                    start_tx = 1'b1;
                end else begin
                    state_d = S_GAP;
                end
            end
            S_RD_RX: begin
                if (ack_ok) begin
                    bus_end = 1'b1;
                    push    = 1'b1;
                    state_d = enable ? S_GAP : S_IDLE;
                end else if (to_hit) begin
                    bus_abort = 1'b1;
                    state_d   = enable ? S_GAP : S_IDLE;
                end
            end
            S_WR_TX: begin
                if (ack_ok) begin
                    bus_end = 1'b1;
                    pop     = 1'b1;
                    state_d = enable ? S_GAP : S_IDLE;
                end else if (to_hit) begin
                    bus_abort = 1'b1;
                    state_d   = enable ? S_GAP : S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Wishbone master outputs: loaded on entry to a bus state, cleared on ack or abort.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wbm_cyc_o <= 1'b0;
            wbm_stb_o <= 1'b0;
            wbm_we_o  <= 1'b0;
            wbm_sel_o <= 4'h0;
            wbm_adr_o <= 32'h0;
            wbm_dat_o <= 32'h0;
        end else if (start_stat || start_rx || start_tx) begin
            wbm_cyc_o <= 1'b1;
            wbm_stb_o <= 1'b1;
            wbm_we_o  <= start_tx;
            wbm_sel_o <= 4'hF;
            wbm_adr_o <= start_stat ? STAT_ADR : (start_rx ? RX_ADR : TX_ADR);
            wbm_dat_o <= start_tx ? {24'h0, mem[rd_ptr[AW-1:0]]} : 32'h0;
        end else if (bus_end || bus_abort) begin
            wbm_cyc_o <= 1'b0;
            wbm_stb_o <= 1'b0;
            wbm_we_o  <= 1'b0;
            wbm_sel_o <= 4'h0;
            wbm_adr_o <= 32'h0;
            wbm_dat_o <= 32'h0;
        end
    end

    // Status bits captured only on the ack of a status read.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_valid_q <= 1'b0;
            tx_busy_q  <= 1'b0;
        end else if (state_q == S_RD_STAT && ack_ok) begin
            rx_valid_q <= wbm_dat_i[RX_VALID_BIT];
            tx_busy_q  <= wbm_dat_i[TX_BUSY_BIT];
        end
    end

    // Poll-gap down-counter and bus-cycle ack timeout counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gap_cnt <= '0;
            to_cnt  <= '0;
        end else begin
            if (state_q != S_GAP) begin
                gap_cnt <= GW'(GAP_LOAD);
            end else if (gap_cnt != '0) begin
                gap_cnt <= gap_cnt - GW'(1);
            end
            if (!wbm_cyc_o) begin
                to_cnt <= '0;
            end else if (to_cnt != TW'(TIMEOUT)) begin
                to_cnt <= to_cnt + TW'(1);
            end
        end
    end

    // FIFO pointers, occupancy (one cycle behind the pointers), counters and sticky error.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_level <= '0;
            echo_count <= 16'h0;
            bus_err    <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + LW'(1);
            end
            if (pop) begin
                rd_ptr     <= rd_ptr + LW'(1);
                echo_count <= echo_count + 16'd1;
            end
            fifo_level <= wr_ptr - rd_ptr;
            if (bus_abort) begin
                bus_err <= 1'b1;
            end
        end
    end

    // FIFO storage; contents need no reset since the pointers define validity.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr[AW-1:0]] <= wbm_dat_i[7:0];
        end
    end

endmodule

// File: tb/tb_uart_echo_master.sv
// Directed bench for uart_echo_master with a reactive UART CSR slave model.
module tb_uart_echo_master;

    localparam logic [31:0] RX_A   = 32'h3000_0000;
    localparam logic [31:0] TX_A   = 32'h3000_0004;
    localparam logic [31:0] STAT_A = 32'h3000_0008;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        enable = 1'b0;
    logic        wbm_cyc_o, wbm_stb_o, wbm_we_o;
    logic [3:0]  wbm_sel_o;
    logic [31:0] wbm_adr_o, wbm_dat_o;
    logic        wbm_ack_i;
    logic [31:0] wbm_dat_i;
    logic [2:0]  fifo_level;
    logic [15:0] echo_count;
    logic        bus_err;

    int n_cmp = 0;
    int n_err = 0;

    // slave model controls and logs
    logic        tx_busy = 1'b0;
    logic        no_ack = 1'b0;
    logic        stall_rx = 1'b0;
    logic        stall_tx = 1'b0;
    logic [7:0]  rx_q[$];
    logic [7:0]  tx_log[$];
    logic [31:0] log_adr[$];
    logic [31:0] log_dat[$];
    logic        log_we[$];
    logic [3:0]  log_sel[$];

    uart_echo_master #(
        .POLL_GAP(2),
        .TIMEOUT(8),
        .FIFO_DEPTH(4)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .enable(enable),
        .wbm_cyc_o(wbm_cyc_o),
        .wbm_stb_o(wbm_stb_o),
        .wbm_we_o(wbm_we_o),
        .wbm_sel_o(wbm_sel_o),
        .wbm_adr_o(wbm_adr_o),
        .wbm_dat_o(wbm_dat_o),
        .wbm_ack_i(wbm_ack_i),
        .wbm_dat_i(wbm_dat_i),
        .fifo_level(fifo_level),
        .echo_count(echo_count),
        .bus_err(bus_err)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // Slave: registered ack one cycle after it sees cyc, read data presented with ack.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wbm_ack_i <= 1'b0;
            wbm_dat_i <= 32'h0;
        end else begin
            wbm_ack_i <= 1'b0;
            if (wbm_cyc_o && !wbm_ack_i && !no_ack &&
                !(stall_rx && wbm_adr_o == RX_A) && !(stall_tx && wbm_we_o)) begin
                wbm_ack_i <= 1'b1;
                log_adr.push_back(wbm_adr_o);
                log_we.push_back(wbm_we_o);
                log_sel.push_back(wbm_sel_o);
                log_dat.push_back(wbm_dat_o);
                if (wbm_we_o) begin
                    tx_log.push_back(wbm_dat_o[7:0]);
                end else if (wbm_adr_o == STAT_A) begin
                    wbm_dat_i <= {27'd0, tx_busy, 3'd0, (rx_q.size() != 0)};
                end else if (wbm_adr_o == RX_A && rx_q.size() != 0) begin
                    wbm_dat_i <= {24'd0, rx_q.pop_front()};
                end else begin
                    wbm_dat_i <= 32'h0;
                end
            end
        end
    end

    task automatic clear_logs();
        log_adr.delete(); log_we.delete(); log_sel.delete(); log_dat.delete(); tx_log.delete();
    endtask

    task automatic test_reset();
        @(negedge clk);
        n_cmp++; if (wbm_cyc_o !== 1'b0) begin n_err++; $display("FAIL rst_cyc: got %0h expected 0", wbm_cyc_o); end
        n_cmp++; if (wbm_stb_o !== 1'b0) begin n_err++; $display("FAIL rst_stb: got %0h expected 0", wbm_stb_o); end
        n_cmp++; if (wbm_we_o !== 1'b0) begin n_err++; $display("FAIL rst_we: got %0h expected 0", wbm_we_o); end
        n_cmp++; if (wbm_sel_o !== 4'h0) begin n_err++; $display("FAIL rst_sel: got %0h expected 0", wbm_sel_o); end
        n_cmp++; if (wbm_adr_o !== 32'h0) begin n_err++; $display("FAIL rst_adr: got %0h expected 0", wbm_adr_o); end
        n_cmp++; if (wbm_dat_o !== 32'h0) begin n_err++; $display("FAIL rst_dat: got %0h expected 0", wbm_dat_o); end
        n_cmp++; if (fifo_level !== 3'd0) begin n_err++; $display("FAIL rst_level: got %0d expected 0", fifo_level); end
        n_cmp++; if (echo_count !== 16'd0) begin n_err++; $display("FAIL rst_echo: got %0d expected 0", echo_count); end
        n_cmp++; if (bus_err !== 1'b0) begin n_err++; $display("FAIL rst_buserr: got %0h expected 0", bus_err); end
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        n_cmp++; if (wbm_cyc_o !== 1'b0) begin n_err++; $display("FAIL idle_no_cyc: got %0h expected 0", wbm_cyc_o); end
    endtask

    task automatic test_single_echo();
        clear_logs();
        rx_q.push_back(8'hA5);
        tx_busy = 1'b0;
        enable = 1'b1;
        for (int i = 0; i < 300 && echo_count != 16'd1; i++) @(negedge clk);
        repeat (3) @(negedge clk);
        n_cmp++; if (echo_count !== 16'd1) begin n_err++; $display("FAIL single_echo_count: got %0d expected 1", echo_count); end
        n_cmp++; if (log_adr[0] !== STAT_A || log_we[0] !== 1'b0) begin n_err++; $display("FAIL single_op0: got adr %0h we %0h expected adr %0h we 0", log_adr[0], log_we[0], STAT_A); end
        n_cmp++; if (log_adr[1] !== RX_A || log_we[1] !== 1'b0) begin n_err++; $display("FAIL single_op1: got adr %0h we %0h expected adr %0h we 0", log_adr[1], log_we[1], RX_A); end
        n_cmp++; if (log_adr[2] !== STAT_A) begin n_err++; $display("FAIL single_op2: got adr %0h expected %0h", log_adr[2], STAT_A); end
        n_cmp++; if (log_adr[3] !== TX_A || log_we[3] !== 1'b1) begin n_err++; $display("FAIL single_op3: got adr %0h we %0h expected adr %0h we 1", log_adr[3], log_we[3], TX_A); end
        n_cmp++; if (log_dat[3] !== 32'h0000_00A5) begin n_err++; $display("FAIL single_wdata: got %0h expected 000000a5", log_dat[3]); end
        n_cmp++; if (log_sel[3] !== 4'hF) begin n_err++; $display("FAIL single_sel: got %0h expected f", log_sel[3]); end
        n_cmp++; if (fifo_level !== 3'd0) begin n_err++; $display("FAIL single_level: got %0d expected 0", fifo_level); end
    endtask

    task automatic test_fifo_full();
        int n_rx;
        int n_wr;
        clear_logs();
        tx_busy = 1'b1;
        for (int i = 1; i <= 6; i++) rx_q.push_back(8'(i));
        repeat (200) @(negedge clk);
        n_rx = 0;
        n_wr = 0;
        for (int i = 0; i < log_adr.size(); i++) begin
            if (log_we[i]) n_wr++;
            else if (log_adr[i] == RX_A) n_rx++;
        end
        n_cmp++; if (n_rx !== 4) begin n_err++; $display("FAIL full_rx_reads: got %0d expected 4", n_rx); end
        n_cmp++; if (n_wr !== 0) begin n_err++; $display("FAIL full_writes: got %0d expected 0", n_wr); end
        n_cmp++; if (fifo_level !== 3'd4) begin n_err++; $display("FAIL full_level: got %0d expected 4", fifo_level); end
        n_cmp++; if (rx_q.size() !== 2) begin n_err++; $display("FAIL full_rx_left: got %0d expected 2", rx_q.size()); end
        n_cmp++; if (log_adr[log_adr.size()-1] !== STAT_A) begin n_err++; $display("FAIL full_last_op: got %0h expected %0h", log_adr[log_adr.size()-1], STAT_A); end
        clear_logs();
        tx_busy = 1'b0;
        for (int i = 0; i < 600 && tx_log.size() < 6; i++) @(negedge clk);
        repeat (5) @(negedge clk);
        n_cmp++; if (tx_log.size() !== 6) begin n_err++; $display("FAIL full_tx_cnt: got %0d expected 6", tx_log.size()); end
        for (int i = 0; i < 6; i++) begin
            n_cmp++; if (tx_log[i] !== 8'(i + 1)) begin n_err++; $display("FAIL full_order[%0d]: got %0h expected %0h", i, tx_log[i], i + 1); end
        end
        n_cmp++; if (echo_count !== 16'd7) begin n_err++; $display("FAIL full_echo_count: got %0d expected 7", echo_count); end
    endtask

    task automatic test_priority();
        tx_busy = 1'b1;
        rx_q.push_back(8'h11);
        for (int i = 0; i < 200 && fifo_level != 3'd1; i++) @(negedge clk);
        enable = 1'b0;
        repeat (30) @(negedge clk);
        clear_logs();
        rx_q.push_back(8'h22);
        tx_busy = 1'b0;
        enable = 1'b1;
        for (int i = 0; i < 400 && tx_log.size() < 2; i++) @(negedge clk);
        repeat (5) @(negedge clk);
        n_cmp++; if (log_adr[1] !== RX_A || log_we[1] !== 1'b0) begin n_err++; $display("FAIL prio_rx_first: got adr %0h we %0h expected adr %0h we 0", log_adr[1], log_we[1], RX_A); end
        n_cmp++; if (log_adr[3] !== TX_A || log_dat[3] !== 32'h11) begin n_err++; $display("FAIL prio_tx_second: got adr %0h dat %0h expected adr %0h dat 11", log_adr[3], log_dat[3], TX_A); end
        n_cmp++; if (tx_log[1] !== 8'h22) begin n_err++; $display("FAIL prio_tx_next: got %0h expected 22", tx_log[1]); end
        n_cmp++; if (echo_count !== 16'd9) begin n_err++; $display("FAIL prio_echo_count: got %0d expected 9", echo_count); end
    endtask

    task automatic test_timeout();
        int hi;
        int lo;
        n_cmp++; if (bus_err !== 1'b0) begin n_err++; $display("FAIL to_pre_buserr: got %0h expected 0", bus_err); end
        for (int i = 0; i < 50 && wbm_cyc_o; i++) @(negedge clk);
        no_ack = 1'b1;
        for (int i = 0; i < 50 && !wbm_cyc_o; i++) @(negedge clk);
        hi = 0;
        while (wbm_cyc_o && hi < 40) begin hi++; @(negedge clk); end
        n_cmp++; if (hi !== 9) begin n_err++; $display("FAIL to_cyc_len: got %0d expected 9", hi); end
        n_cmp++; if (bus_err !== 1'b1) begin n_err++; $display("FAIL to_buserr: got %0h expected 1", bus_err); end
        no_ack = 1'b0;
        lo = 0;
        while (!wbm_cyc_o && lo < 40) begin lo++; @(negedge clk); end
        n_cmp++; if (lo !== 2) begin n_err++; $display("FAIL to_gap_len: got %0d expected 2", lo); end
        n_cmp++; if (wbm_adr_o !== STAT_A) begin n_err++; $display("FAIL to_resume_adr: got %0h expected %0h", wbm_adr_o, STAT_A); end
        repeat (20) @(negedge clk);
        n_cmp++; if (bus_err !== 1'b1) begin n_err++; $display("FAIL to_sticky: got %0h expected 1", bus_err); end
    endtask

    task automatic test_enable_mid();
        int hi;
        stall_rx = 1'b1;
        tx_busy = 1'b1;
        rx_q.push_back(8'h33);
        for (int i = 0; i < 100 && !(wbm_cyc_o && wbm_adr_o == RX_A); i++) @(negedge clk);
        n_cmp++; if (!(wbm_cyc_o && wbm_adr_o == RX_A)) begin n_err++; $display("FAIL en_rx_seen: got cyc %0h adr %0h expected cyc 1 adr %0h", wbm_cyc_o, wbm_adr_o, RX_A); end
        enable = 1'b0;
        repeat (3) @(negedge clk);
        stall_rx = 1'b0;
        repeat (4) @(negedge clk);
        hi = 0;
        for (int i = 0; i < 20; i++) begin
            if (wbm_cyc_o) hi++;
            @(negedge clk);
        end
        n_cmp++; if (hi !== 0) begin n_err++; $display("FAIL en_idle_cyc: got %0d expected 0", hi); end
        n_cmp++; if (fifo_level !== 3'd1) begin n_err++; $display("FAIL en_level: got %0d expected 1", fifo_level); end
        n_cmp++; if (rx_q.size() !== 0) begin n_err++; $display("FAIL en_rx_drained: got %0d expected 0", rx_q.size()); end
    endtask

    task automatic test_reset_mid();
        stall_tx = 1'b1;
        tx_busy = 1'b0;
        enable = 1'b1;
        for (int i = 0; i < 100 && !(wbm_cyc_o && wbm_we_o); i++) @(negedge clk);
        n_cmp++; if (wbm_dat_o !== 32'h33) begin n_err++; $display("FAIL rm_wdata: got %0h expected 33", wbm_dat_o); end
        #2 rst_n = 1'b0;
        #1;
        n_cmp++; if (wbm_cyc_o !== 1'b0 || wbm_stb_o !== 1'b0) begin n_err++; $display("FAIL rm_cyc: got cyc %0h stb %0h expected 0 0", wbm_cyc_o, wbm_stb_o); end
        n_cmp++; if (wbm_we_o !== 1'b0 || wbm_sel_o !== 4'h0) begin n_err++; $display("FAIL rm_we_sel: got we %0h sel %0h expected 0 0", wbm_we_o, wbm_sel_o); end
        n_cmp++; if (wbm_adr_o !== 32'h0 || wbm_dat_o !== 32'h0) begin n_err++; $display("FAIL rm_adr_dat: got adr %0h dat %0h expected 0 0", wbm_adr_o, wbm_dat_o); end
        n_cmp++; if (fifo_level !== 3'd0) begin n_err++; $display("FAIL rm_level: got %0d expected 0", fifo_level); end
        n_cmp++; if (echo_count !== 16'd0) begin n_err++; $display("FAIL rm_echo: got %0d expected 0", echo_count); end
        n_cmp++; if (bus_err !== 1'b0) begin n_err++; $display("FAIL rm_buserr: got %0h expected 0", bus_err); end
        enable = 1'b0;
        stall_tx = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_back_to_back();
        clear_logs();
        for (int i = 0; i < 10; i++) rx_q.push_back(8'h40 + 8'(i));
        tx_busy = 1'b0;
        enable = 1'b1;
        for (int i = 0; i < 1500 && tx_log.size() < 10; i++) @(negedge clk);
        repeat (5) @(negedge clk);
        n_cmp++; if (tx_log.size() !== 10) begin n_err++; $display("FAIL wrap_tx_cnt: got %0d expected 10", tx_log.size()); end
        for (int i = 0; i < 10; i++) begin
            n_cmp++; if (tx_log[i] !== 8'h40 + 8'(i)) begin n_err++; $display("FAIL wrap_order[%0d]: got %0h expected %0h", i, tx_log[i], 8'h40 + 8'(i)); end
        end
        n_cmp++; if (echo_count !== 16'd10) begin n_err++; $display("FAIL wrap_echo_count: got %0d expected 10", echo_count); end
        n_cmp++; if (fifo_level !== 3'd0) begin n_err++; $display("FAIL wrap_level: got %0d expected 0", fifo_level); end
    endtask

    initial begin
        test_reset();
        test_single_echo();
        test_fifo_full();
        test_priority();
        test_timeout();
        test_enable_mid();
        test_reset_mid();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
